// File: rtl/lsu_pkg.sv
// Shared encodings and defaults for the load/store unit: access sizes, FSM states,
// memory geometry and the alignment rule.
package lsu_pkg;

  localparam int DEF_DEPTH = 128;
  localparam int DEF_AW    = 9;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Size 11 is never a legal access, so it is reported together with misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      SZ_X:    bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus the word-addressed data memory port.
// The slave modport is the load/store unit; master is the core/memory side.
interface load_store_unit_if #(
  parameter int AW = 9
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends a load lane, and merges store data into a word.
// Purely combinational, little-endian lanes (byte k at bits [8k+7:8k]).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word_i[{off_i, 3'b000} +: 8];
    half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_B:    load_o = unsigned_i ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_H:    load_o = unsigned_i ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (size_i)
      SZ_B: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_H: begin
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word memory; error 1, load/word store 2, sub-word store 3 cycles.
// One access in flight: req_ready drops on accept and returns after the single-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  lsu_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic [AW-1:0] req_idx;
  logic [1:0]    req_off;
  logic          req_illegal;
  logic [31:0]   ld_data;
  logic [31:0]   st_merge;

  assign req_idx     = bus.req_addr[AW+1:2];
  assign req_off     = bus.req_addr[1:0];
  assign req_illegal = misaligned(bus.req_size, req_off) || ({1'b0, req_idx} >= DEPTH_LIM);

  lsu_align u_align (
    .size_i     (size_q),
    .off_i      (off_q),
    .unsigned_i (uns_q),
    .word_i     (bus.mem_rdata),
    .wdata_i    (wdata_q),
    .load_o     (ld_data),
    .merge_o    (st_merge)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          off_d   = req_off;
          wdata_d = bus.req_wdata;
          if (req_illegal) begin
            // Rejected accesses leave the memory port untouched.
            resp_err_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            mem_addr_d  = req_idx;
            mem_wdata_d = bus.req_wdata;
            state_d     = (bus.req_we && bus.req_size == SZ_W) ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_READ: begin
        if (we_q) begin
          mem_wdata_d = st_merge;
          state_d     = ST_WRITE;
        end else begin
          resp_rdata_d = ld_data;
          state_d      = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Every output is registered from the next state, so none is combinational from inputs.
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    mem_read_d   = (state_d == ST_READ);
    mem_write_d  = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
